// File: rtl/normalize_stream.sv
// Multi-channel sample normalizer: offset, scale, gain and saturate, as a
// 3-stage valid/ready pipeline with a sticky saturation flag and frame counter.
module normalize_stream #(
  parameter int N_CH       = 2,
  parameter int IN_W       = 32,
  parameter int OUT_W      = 18,
  parameter int OFFSET     = 262143,
  parameter int SCALE      = 10000,
  parameter int SHIFT      = 19,
  parameter int GAIN       = 1677,
  parameter int FRAC_SHIFT = 14
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*IN_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_CH*OUT_W-1:0]  out_data,
  output logic                   sat_flag,
  output logic [15:0]            frame_cnt
);

  localparam int S_W = IN_W + 1;
  localparam logic [63:0] Y_MAX = (64'd1 << OUT_W) - 64'd1;

  logic                    advance;
  logic                    v1_r;
  logic                    v2_r;
  logic                    clamp3_r;
  logic signed [S_W-1:0]   s_next [N_CH];
  logic signed [S_W-1:0]   s_r    [N_CH];
  logic [63:0]             d_next [N_CH];
  logic [63:0]             d_r    [N_CH];
  logic [63:0]             prod   [N_CH];
  logic [N_CH-1:0]         neg_next;
  logic [N_CH-1:0]         neg_r;
  logic [N_CH-1:0]         over;
  logic [N_CH*OUT_W-1:0]   y_next;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Per-lane arithmetic for all three stages; negative sums are carried to S3 as clamps.
  always_comb begin
    y_next = '0;
    for (int k = 0; k < N_CH; k++) begin
      s_next[k]   = S_W'($signed(in_data[k*IN_W +: IN_W])) + S_W'(OFFSET);
      neg_next[k] = s_r[k][S_W-1];
      if (s_r[k][S_W-1]) begin
        d_next[k] = 64'd0;
      end else begin
        d_next[k] = (64'($unsigned(s_r[k])) * 64'(SCALE)) >> SHIFT;
      end
      prod[k] = (d_r[k] * 64'(GAIN)) >> FRAC_SHIFT;
      over[k] = (prod[k] > Y_MAX);
      if (over[k]) begin
        y_next[k*OUT_W +: OUT_W] = OUT_W'(Y_MAX);
      end else begin
        y_next[k*OUT_W +: OUT_W] = OUT_W'(prod[k]);
      end
    end
  end

  // Pipeline stages move together only when the output slot is free or draining.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      clamp3_r  <= 1'b0;
      sat_flag  <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      if (advance) begin
        v1_r      <= in_valid;
        v2_r      <= v1_r;
        out_valid <= v2_r;
        s_r       <= s_next;
        d_r       <= d_next;
        neg_r     <= neg_next;
        out_data  <= y_next;
        clamp3_r  <= v2_r && (|(neg_r | over));
      end
      if (out_valid && clamp3_r) begin
        sat_flag <= 1'b1;
      end
      if (out_valid && out_ready) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
